fifo_read_drainer: RTL
======================

Name: fifo_read_drainer

Overview:
- Read-side consumer for asynchronous_FIFO, running entirely in the read clock domain.
- Pops words from the FIFO read port (ren/rack/rdata/remty) whenever the FIFO is non-empty and local space exists, then buffers them in a 2-entry skid buffer.
- Presents the words on a valid/ready stream, counts delivered words and reports idle.
- Counterpart to the write-side stimulus/producer; used in the FIFO bench and as the read front-end in system integration.

Parameters:
- DATASIZE, 8, data word width; must match definitions::DATASIZE.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- rclk  in  1  read-domain clock; all logic on posedge.
- rrst_n  in  1  asynchronous active-low reset.
- drain_en  in  1  1 = drain the FIFO; 0 = stop issuing new pops.
- ren  out  1  pop request to the FIFO.
- rack  in  1  FIFO read acknowledge; rdata valid while rack=1.
- rdata  in  DATASIZE  FIFO read data.
- remty  in  1  FIFO empty flag, synchronous to rclk.
- out_valid  out  1  stream data valid.
- out_data  out  DATASIZE  stream data.
- out_ready  in  1  downstream accept.
- word_count  out  CNT_W  words delivered downstream; wraps.
- ridle  out  1  1 = IDLE state, buffer empty, no pop outstanding.
- proto_err  out  1  sticky: rack received with no pop outstanding.

Behaviour:
- Reset (async assert, sync release on rclk):
  - State = IDLE.
  - occ = 0, pend = 0.
  - ren = 0, out_valid = 0, out_data = 0, word_count = 0, ridle = 1, proto_err = 0.
- FIFO protocol:
  - A pop is issued in every cycle where ren=1.
  - The FIFO answers with rack=1 and valid rdata exactly 1 cycle later.
  - pend (0..1) = number of pops issued but not yet acked.
- ren is combinational from registered state:
  - ren = (state==ACTIVE) && !remty && (occ + pend_next_free) < 2.
  - In practice: occ + pend must stay <= 2 after the pop.
  - No pop is ever issued that could overflow the skid buffer.
- Capture:
  - rack=1 with pend=1: push rdata into the skid buffer and clear pend (unless a new pop is issued in the same cycle).
  - rack=1 with pend=0: data dropped, proto_err set to 1 until reset.
- Skid buffer:
  - 2 entries, in-order.
  - out_valid = (occ != 0); out_data = head entry.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle: occ unchanged, order preserved.
  - With out_ready held at 1, sustained throughput is 1 word/cycle.
  - out_data stays stable while out_valid=1 && out_ready=0.
- word_count: +1 per out handshake; wraps from 2^CNT_W-1 to 0.
- FSM:
  - IDLE -> ACTIVE when drain_en=1.
  - ACTIVE -> DRAIN when drain_en=0.
  - DRAIN: ren forced 0; waits for pend=0 and occ=0, then -> IDLE.
  - DRAIN -> ACTIVE if drain_en returns to 1 before completion.
  - ridle = (state==IDLE); occ=0 and pend=0 are guaranteed in IDLE.
- Boundaries:
  - remty rising while a pop is outstanding: the outstanding ack is still accepted; no further ren.
  - out_ready=0 for long periods: ren drops once occ + pend = 2; no word is lost or duplicated.
  - Reset mid-transfer: buffer contents and any pending ack are discarded; a rack arriving in the first cycle after reset release sets proto_err.

Optional Feature:
- Macro: SEQ_CHECK_EN.
- When defined:
  - Adds output seq_err (1 bit, sticky) and output seq_err_cnt (8 bits, saturating at 255).
  - The first word delivered after reset sets the baseline.
  - Each later delivered word must equal previous + 1 mod 2^DATASIZE; on mismatch, seq_err=1 and seq_err_cnt increments.
  - Both outputs reset to 0.
- When undefined: neither port nor the logic exists; all other behaviour is identical.

Test Plan:
- Reset: rrst_n=0 mid-simulation -> within the same cycle all outputs at reset values; ridle=1, word_count=0.
- Stream: FIFO model holds 10 words 0..9, drain_en=1, out_ready=1:
  - first out_valid 2 cycles after ren;
  - 10 words delivered in order on consecutive cycles;
  - word_count=10; ridle=1 after drain_en=0.
- Backpressure: out_ready=0 with 5 words available -> ren pulses at most twice, occ=2, out_data=0 stable; release out_ready -> 0..4 delivered with no loss or duplicates.
- Empty toggling: remty alternates every 3 cycles -> ren=0 whenever remty=1; all available words delivered in order.
- drain_en=0 with a pop outstanding -> ack captured, buffer flushed, ridle=1 only after the last handshake.
- SEQ_CHECK_EN: deliver 0,1,2,4,5 -> seq_err=1 after the word 4, seq_err_cnt=1; unchanged after 5. Spurious rack with pend=0 -> proto_err=1.

Source files
------------

// File: rtl/fifo_read_drainer_if.sv
// FIFO read-port and output-stream signals of fifo_read_drainer, bundled with drainer-side (master)
// and FIFO/sink-side (slave) views.
interface fifo_read_drainer_if #(
    parameter int DATASIZE = 8
);
    logic                ren;
    logic                rack;
    logic [DATASIZE-1:0] rdata;
    logic                remty;
    logic                out_valid;
    logic [DATASIZE-1:0] out_data;
    logic                out_ready;

    modport master (
        output ren,
        input  rack,
        input  rdata,
        input  remty,
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  ren,
        output rack,
        output rdata,
        output remty,
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/fifo_read_drainer.sv
// Read-domain FIFO consumer: pops into a 2-entry skid buffer and delivers on a valid/ready stream.
// Optional macro SEQ_CHECK_EN adds an incrementing-sequence checker (seq_err, seq_err_cnt).
module fifo_read_drainer #(
    parameter int DATASIZE = 8,
    parameter int CNT_W    = 16
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                drain_en,
    fifo_read_drainer_if.master bus,
    output logic [CNT_W-1:0]    word_count,
    output logic                ridle,
    output logic                proto_err
`ifdef SEQ_CHECK_EN
    ,
    output logic                seq_err,
    output logic [7:0]          seq_err_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [1:0]          occ_q, occ_d;
    logic                pend_q, pend_d;
    logic [DATASIZE-1:0] ent0_q, ent0_d;
    logic [DATASIZE-1:0] ent1_q, ent1_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                perr_q, perr_d;
    logic                push, pop, ren;
    logic [1:0]          occ_after_pop;

    assign pop  = (occ_q != 2'd0) && bus.out_ready;
    assign push = bus.rack && pend_q;

    // A slot emptied by this cycle's handshake may be claimed by a pop issued now, since
    // its data lands one cycle later; this is what sustains one word per cycle.
    assign occ_after_pop = occ_q - {1'b0, pop};
    assign ren = (state_q == ACTIVE) && !bus.remty
                 && ((occ_after_pop + {1'b0, pend_q}) < 2'd2);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (drain_en) state_d = ACTIVE;
            ACTIVE:  if (!drain_en) state_d = DRAIN;
            DRAIN: begin
                if (drain_en)
                    state_d = ACTIVE;
                else if (!pend_q && (occ_q == 2'd0))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pend_d = pend_q;
        if (ren)
            pend_d = 1'b1;
        else if (bus.rack)
            pend_d = 1'b0;

        perr_d = perr_q | (bus.rack & ~pend_q);
        cnt_d  = pop ? cnt_q + 1'b1 : cnt_q;

        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    ent0_d = bus.rdata;
                    occ_d  = 2'd1;
                end else if (occ_q == 2'd1) begin
                    ent1_d = bus.rdata;
                    occ_d  = 2'd2;
                end
            end
            2'b01: begin
                ent0_d = ent1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    ent0_d = bus.rdata;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = bus.rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= IDLE;
            occ_q   <= 2'd0;
            pend_q  <= 1'b0;
            ent0_q  <= '0;
            ent1_q  <= '0;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            pend_q  <= pend_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
        end
    end

    assign bus.ren       = ren;
    assign bus.out_valid = (occ_q != 2'd0);
    assign bus.out_data  = ent0_q;
    assign word_count    = cnt_q;
    assign ridle         = (state_q == IDLE);
    assign proto_err     = perr_q;

`ifdef SEQ_CHECK_EN
    logic [DATASIZE-1:0] prev_q, prev_d, prev_inc;
    logic                base_q, base_d;
    logic                serr_q, serr_d;
    logic [7:0]          scnt_q, scnt_d;

    assign prev_inc = prev_q + 1'b1;

    // The first delivered word after reset only establishes the baseline.
    always_comb begin
        prev_d = prev_q;
        base_d = base_q;
        serr_d = serr_q;
        scnt_d = scnt_q;
        if (pop) begin
            prev_d = ent0_q;
            base_d = 1'b1;
            if (base_q && (ent0_q != prev_inc)) begin
                serr_d = 1'b1;
                if (scnt_q != 8'hFF)
                    scnt_d = scnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            prev_q <= '0;
            base_q <= 1'b0;
            serr_q <= 1'b0;
            scnt_q <= 8'd0;
        end else begin
            prev_q <= prev_d;
            base_q <= base_d;
            serr_q <= serr_d;
            scnt_q <= scnt_d;
        end
    end

    assign seq_err     = serr_q;
    assign seq_err_cnt = scnt_q;
`endif
endmodule
